// File: rtl/osc_edge_meter.sv
`default_nettype none
// ============================================================================
//  Module   : osc_edge_meter
//  Purpose  : Counts rising edges of an asynchronous (e.g. self-oscillating)
//             signal over a fixed gate window of clk cycles and reports the
//             saturating count with a one-cycle done strobe.
//  Ports    : clk      - system clock, rising edge
//             rst      - synchronous reset, active-high
//             osc_in   - asynchronous signal under measurement
//             start    - measurement request (level, sampled in IDLE)
//             busy     - high while the gate window is open
//             done     - one-cycle strobe, count/overflow just updated
//             count    - rising edges seen in the last window (saturating)
//             overflow - last window's edge total exceeded 2^CNT_W-1
//  Revision : 1.0 - initial release
// ============================================================================
module osc_edge_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             osc_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    // Gate counter runs 0..GATE_CYCLES-1 while in MEASURE.
    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic               prev_q;
    logic               osc_s;
    logic               rise;
    logic [GATE_W-1:0]  gate_q, gate_d;
    logic [CNT_W-1:0]   edge_q, edge_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    assign osc_s = sync_q[SYNC_STAGES-1];
    // prev_q tracks osc_s every cycle, including IDLE, so the first MEASURE
    // cycle compares against a real previous sample and sees no false edge.
    assign rise  = osc_s & ~prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            state_q    <= ST_IDLE;
            gate_q     <= '0;
            edge_q     <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], osc_in};
            prev_q     <= osc_s;
            state_q    <= state_d;
            gate_q     <= gate_d;
            edge_q     <= edge_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        edge_d     = edge_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gate_d = '0;
                edge_d = '0;
                ovf_d  = 1'b0;
                if (start) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                busy   = 1'b1;
                gate_d = gate_q + 1'b1;
                if (rise) begin
                    if (edge_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_d = edge_q + 1'b1;
                    end
                end
                // Load results from the next-state values so a rise in the
                // final MEASURE cycle is still included.
                if (gate_q == GATE_LAST) begin
                    state_d    = ST_REPORT;
                    count_d    = edge_d;
                    overflow_d = ovf_d;
                end
            end
            ST_REPORT: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_osc_edge_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_osc_edge_meter
//  Purpose  : Scoreboard bench for osc_edge_meter (GATE_CYCLES=100, CNT_W=4).
//             Stimulus pushes expected window results; a monitor pops them on
//             every done strobe and also checks window length and spacing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_osc_edge_meter;

    localparam int GATE = 100;
    localparam int CW   = 4;

    typedef struct {
        int cnt;
        int tol;
        bit ovf;
        int gap;   // required cycles since previous done, 0 = unchecked
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          osc_in = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [CW-1:0] count;
    logic          overflow;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_done = 0;
    int   cyc = 0;
    int   osc_half = 0;
    logic osc_level = 1'b0;
    int   osc_ph = 0;
    exp_t sb[$];

    osc_edge_meter #(
        .SYNC_STAGES(2),
        .GATE_CYCLES(GATE),
        .CNT_W      (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .osc_in  (osc_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Oscillator model: toggles every osc_half clk cycles, or static level.
    always @(negedge clk) begin
        if (osc_half == 0) begin
            osc_in = osc_level;
            osc_ph = 0;
        end else if (osc_ph >= osc_half - 1) begin
            osc_in = ~osc_in;
            osc_ph = 0;
        end else begin
            osc_ph++;
        end
    end

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard
    int busy_run = 0;
    int last_done_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        int   diff;
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                n_done++;
                check("busy_in_report", busy == 1'b0, int'(busy), 0);
                check("window_length", busy_run == GATE, busy_run, GATE);
                busy_run = 0;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b0, 1, 0);
                end else begin
                    e    = sb.pop_front();
                    diff = int'(count) - e.cnt;
                    if (diff < 0) diff = -diff;
                    check("count", diff <= e.tol, int'(count), e.cnt);
                    check("overflow", overflow == e.ovf, int'(overflow), int'(e.ovf));
                    if (e.gap != 0)
                        check("done_spacing", (cyc - last_done_cyc) == e.gap,
                              cyc - last_done_cyc, e.gap);
                end
                last_done_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic push(input int c, input int t, input bit o, input int g);
        exp_t e;
        e.cnt = c; e.tol = t; e.ovf = o; e.gap = g;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            tick(1);
            k++;
        end
        if (n_done < target) check("done_timeout", 1'b0, n_done, target);
    endtask

    task automatic set_static(input logic lvl);
        osc_half  = 0;
        osc_level = lvl;
        tick(10);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        tick(4);
        check("rst_busy", busy == 1'b0, int'(busy), 0);
        check("rst_done", done == 1'b0, int'(done), 0);
        check("rst_count", count == '0, int'(count), 0);
        check("rst_overflow", overflow == 1'b0, int'(overflow), 0);
        rst = 1'b0;
        tick(3);

        // Toggle every 5 clk: one rise per 10 cycles -> 10 rises in 100.
        osc_half = 5;
        push(10, 1, 1'b0, 0);
        pulse_start();
        wait_done(1, GATE + 20);
        tick(3);

        // Static high, then static low: nothing counted.
        set_static(1'b1);
        push(0, 0, 1'b0, 0);
        pulse_start();
        wait_done(2, GATE + 20);
        set_static(1'b0);
        push(0, 0, 1'b0, 0);
        pulse_start();
        wait_done(3, GATE + 20);

        // Toggle every 2 clk: 25 rises saturate a 4-bit counter.
        osc_half = 2;
        tick(5);
        push(15, 0, 1'b1, 0);
        pulse_start();
        wait_done(4, GATE + 20);
        set_static(1'b0);
        push(0, 0, 1'b0, 0);
        pulse_start();
        wait_done(5, GATE + 20);

        // Start re-pulsed inside the window is ignored.
        osc_half = 5;
        tick(5);
        push(10, 1, 1'b0, 0);
        pulse_start();
        tick(9);
        pulse_start();
        tick(39);
        pulse_start();
        wait_done(6, GATE + 20);
        tick(30);
        check("no_extra_done", n_done == 6, n_done, 6);

        // Reset mid-window: abandoned, no done, outputs cleared.
        pulse_start();
        tick(40);
        check("busy_mid_window", busy == 1'b1, int'(busy), 1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_busy", busy == 1'b0, int'(busy), 0);
        check("mid_rst_count", count == '0, int'(count), 0);
        rst = 1'b0;
        tick(GATE + 20);
        check("no_done_after_rst", n_done == 6, n_done, 6);

        // Start held high: back-to-back windows every GATE+2 cycles.
        osc_half = 10;
        tick(5);
        base = n_done;
        push(5, 1, 1'b0, 0);
        push(5, 1, 1'b0, GATE + 2);
        push(5, 1, 1'b0, GATE + 2);
        start = 1'b1;
        wait_done(base + 2, 2 * GATE + 40);
        tick(5);
        start = 1'b0;
        wait_done(base + 3, GATE + 20);
        tick(GATE + 20);
        check("held_done_total", n_done == base + 3, n_done, base + 3);
        check("scoreboard_empty", sb.size() == 0, sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
